// File: rtl/uart_rx_buffer.sv
// 8N1 UART receiver (4x oversampled) feeding a 2^ADDR_WIDTH-byte RAM FIFO.
// The bus side pops one byte per strobe; overrun and frame errors are sticky until cleared.
module uart_rx_buffer #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  baud_x4,
   input  logic                  serial_rx,
   input  logic                  rd_strobe,
   input  logic                  clr_err,
   output logic [7:0]            rd_data,
   output logic                  rd_ack,
   output logic                  rd_avail,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overrun,
   output logic                  frame_err
);

   localparam int unsigned PtrW  = ADDR_WIDTH + 1;
   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} rx_state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;

   rx_state_e  state_q, state_d;
   logic [1:0] tick_q, tick_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shreg_q, shreg_d;
   logic       wr_req_q, wr_req_d;
   logic       frame_set;

   logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q;
   logic [7:0]      mem [Depth];
   logic [7:0]      rd_data_q;
   logic            rd_ack_q, overrun_q, frame_err_q;
   logic            full, pop, push, overrun_set;

   assign rx_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      wr_req_d  = 1'b0;
      frame_set = 1'b0;
      if (baud_x4) begin
         unique case (state_q)
            StIdle: begin
               if (!rx_s) begin
                  state_d = StStart;
                  tick_d  = 2'd0;
               end
            end
            StStart: begin
               tick_d = tick_q + 2'd1;
               if (tick_q == 2'd1) begin
                  if (!rx_s) begin
                     state_d = StData;
                     tick_d  = 2'd0;
                     bit_d   = 3'd0;
                  end else begin
                     state_d = StIdle;
                  end
               end
            end
            StData: begin
               tick_d = tick_q + 2'd1;
               if (tick_q == 2'd3) begin
                  shreg_d = {rx_s, shreg_q[7:1]};
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_d = StStop;
                     tick_d  = 2'd0;
                  end
               end
            end
            StStop: begin
               tick_d = tick_q + 2'd1;
               if (tick_q == 2'd3) begin
                  if (rx_s) begin
                     wr_req_d = 1'b1;
                     state_d  = StIdle;
                  end else begin
                     frame_set = 1'b1;
                     state_d   = StBreak;
                  end
               end
            end
            StBreak: begin
               if (rx_s) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // A pop in the same cycle frees a slot, so a write into a full FIFO is still accepted.
   assign full        = (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]) &&
                        (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]);
   assign pop         = rd_strobe && (count_q != '0);
   assign push        = wr_req_q && (!full || pop);
   assign overrun_set = wr_req_q && full && !pop;
   assign wptr_d      = wptr_q + PtrW'(push);
   assign rptr_d      = rptr_q + PtrW'(pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q      <= '1;
         state_q     <= StIdle;
         tick_q      <= 2'd0;
         bit_q       <= 3'd0;
         shreg_q     <= 8'd0;
         wr_req_q    <= 1'b0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         rd_ack_q    <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], serial_rx};
         state_q     <= state_d;
         tick_q      <= tick_d;
         bit_q       <= bit_d;
         shreg_q     <= shreg_d;
         wr_req_q    <= wr_req_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= wptr_d - rptr_d;
         rd_ack_q    <= pop;
         // Set has priority over clear.
         overrun_q   <= overrun_set || (overrun_q && !clr_err);
         frame_err_q <= frame_set || (frame_err_q && !clr_err);
      end
   end

   // Kept reset-free so the array maps onto block RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr_q[ADDR_WIDTH-1:0]] <= shreg_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q <= 8'd0;
      end else if (pop) begin
         rd_data_q <= mem[rptr_q[ADDR_WIDTH-1:0]];
      end
   end

   assign rd_data   = rd_data_q;
   assign rd_ack    = rd_ack_q;
   assign rd_avail  = (count_q != '0);
   assign count     = count_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed/randomized bench for uart_rx_buffer; expected bytes and flags come from a
// queue model of the FIFO and sticky error rules.
module tb_uart_rx_buffer;

   localparam int unsigned AW    = 8;
   localparam int unsigned Depth = 256;
   // Edge driven 2 ns after tick posedge P; 2-flop sync, detect at P+1 tick,
   // stop sampled 38 ticks later, write 1 clk after that: 39*4+1 clk after P.
   localparam int unsigned WrDelay = 157;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          baud_x4 = 1'b0;
   logic          serial_rx = 1'b1;
   logic          rd_strobe = 1'b0;
   logic          clr_err = 1'b0;
   logic [7:0]    rd_data;
   logic          rd_ack;
   logic          rd_avail;
   logic [AW:0]   count;
   logic          overrun;
   logic          frame_err;

   int         total = 0;
   int         bad = 0;
   int         div = 0;
   logic [7:0] exp_q[$];
   logic       exp_ovr = 1'b0;
   logic       exp_ferr = 1'b0;

   uart_rx_buffer #(.ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .baud_x4   (baud_x4),
      .serial_rx (serial_rx),
      .rd_strobe (rd_strobe),
      .clr_err   (clr_err),
      .rd_data   (rd_data),
      .rd_ack    (rd_ack),
      .rd_avail  (rd_avail),
      .count     (count),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   initial forever #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      baud_x4 = (div == 3);
      div = (div + 1) % 4;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Wait until the posedge just passed carried a baud tick.
   task automatic align();
      while (!baud_x4) step(1);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      serial_rx = 1'b0;
      step(16);
      for (int i = 0; i < 8; i++) begin
         serial_rx = b[i];
         step(16);
      end
      serial_rx = stop_bit;
      step(16);
   endtask

   task automatic send(input logic [7:0] b);
      align();
      send_frame(b, 1'b1);
      if (exp_q.size() < Depth) exp_q.push_back(b);
      else exp_ovr = 1'b1;
   endtask

   task automatic pop_expect(input string tag);
      logic [7:0] e;
      e = exp_q.pop_front();
      rd_strobe = 1'b1;
      step(1);
      rd_strobe = 1'b0;
      check({tag, "_ack"}, 32'(rd_ack), 32'd1);
      check({tag, "_data"}, 32'(rd_data), 32'(e));
   endtask

   task automatic check_status(input string tag);
      check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
      check({tag, "_avail"}, 32'(rd_avail), 32'(exp_q.size() != 0));
      check({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
      check({tag, "_frame_err"}, 32'(frame_err), 32'(exp_ferr));
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() > 0) pop_expect(tag);
      check_status({tag, "_empty"});
   endtask

   initial begin
      logic [7:0] nb;
      logic [7:0] e;
      logic [7:0] last;

      // Reset state
      step(4);
      check("rst_data", 32'(rd_data), 32'd0);
      check("rst_ack", 32'(rd_ack), 32'd0);
      check_status("rst");
      reset = 1'b0;
      step(8);

      // Single byte
      send(8'h55);
      check_status("single");
      pop_expect("single_pop");
      check_status("single_post");

      // Burst and ordering, then a strobe on an empty FIFO
      send(8'h41);
      send(8'h42);
      send(8'h43);
      check_status("burst");
      rd_strobe = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         e = exp_q.pop_front();
         last = e;
         check("burst_ack", 32'(rd_ack), 32'd1);
         check("burst_data", 32'(rd_data), 32'(e));
      end
      step(1);
      rd_strobe = 1'b0;
      check("burst_4th_ack", 32'(rd_ack), 32'd0);
      check("burst_4th_hold", 32'(rd_data), 32'(last));
      check_status("burst_post");

      // Fill, then overflow
      for (int i = 0; i < 256; i++) send(8'(i));
      check_status("full");
      send(8'hAA);
      check_status("full_ovr");
      clr_err = 1'b1;
      step(1);
      clr_err = 1'b0;
      exp_ovr = 1'b0;
      check_status("clr_ovr");

      // Pop lands in the same cycle as the write into a full FIFO
      nb = 8'($urandom);
      e = exp_q.pop_front();
      align();
      fork
         send_frame(nb, 1'b1);
         begin
            step(WrDelay - 1);
            rd_strobe = 1'b1;
            step(1);
            rd_strobe = 1'b0;
            check("simul_ack", 32'(rd_ack), 32'd1);
            check("simul_data", 32'(rd_data), 32'(e));
         end
      join
      exp_q.push_back(nb);
      check_status("simul");

      // Overrun again, then framing error while full
      send(8'hBB);
      check_status("ovr2");
      align();
      send_frame(8'h3C, 1'b0);
      exp_ferr = 1'b1;
      check_status("frame");
      clr_err = 1'b1;
      step(1);
      clr_err = 1'b0;
      exp_ovr = 1'b0;
      exp_ferr = 1'b0;
      check_status("clr_both");
      step(640);
      check_status("break_hold");
      serial_rx = 1'b1;
      step(48);
      pop_expect("pre7e_pop");
      send(8'h7E);
      check_status("after_7e");
      drain("drain_full");

      // Random traffic with interleaved pops across the pointer wrap
      for (int i = 0; i < 80; i++) begin
         send(8'($urandom));
         if ($urandom_range(0, 2) != 0 && exp_q.size() > 0) pop_expect("wrap");
      end
      check_status("wrap_mid");
      drain("wrap_drain");

      // Short low glitch on an idle line
      align();
      step($urandom_range(0, 3));
      serial_rx = 1'b0;
      step(6);
      serial_rx = 1'b1;
      step(200);
      check_status("glitch");

      // Reset during bit 4 of 0x99 with a byte already stored
      send(8'h5A);
      check_status("pre_reset");
      align();
      nb = 8'h99;
      serial_rx = 1'b0;
      step(16);
      for (int i = 0; i < 4; i++) begin
         serial_rx = nb[i];
         step(16);
      end
      serial_rx = nb[4];
      step(8);
      reset = 1'b1;
      step(2);
      serial_rx = 1'b1;
      step(1);
      reset = 1'b0;
      exp_q.delete();
      exp_ovr = 1'b0;
      exp_ferr = 1'b0;
      step(1);
      check("mid_reset_data", 32'(rd_data), 32'd0);
      check("mid_reset_ack", 32'(rd_ack), 32'd0);
      check_status("mid_reset");
      step(64);
      check_status("post_reset_idle");
      send(8'h12);
      check_status("after_12");
      pop_expect("pop_12");
      check_status("end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
